// File: rtl/mult_acc_32.sv
// Result stage for the 16x16 signed multiplier: accumulates 32-bit products into a
// wide signed accumulator and presents sum/count/overflow on a valid/ready port.
module mult_acc_32 #(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 8,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             prod_valid,
  input  logic [31:0]      prod,
  output logic             prod_ready,
  input  logic             acc_clr,
  input  logic             acc_dump,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_cnt,
  output logic             res_ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             prod_ready_d, res_valid_d, res_ovf_d;
  logic [ACC_W-1:0] res_data_d;
  logic [CNT_W-1:0] res_cnt_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_base, sum;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_base, accept, sum_ovf;

  assign prod_ext = ACC_W'($signed(prod));

  // State and result registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      prod_ready <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_cnt    <= '0;
      res_ovf    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      prod_ready <= prod_ready_d;
      res_valid  <= res_valid_d;
      res_data   <= res_data_d;
      res_cnt    <= res_cnt_d;
      res_ovf    <= res_ovf_d;
    end
  end

  // Next-state, accumulate and result capture
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    res_valid_d  = res_valid;
    res_data_d   = res_data;
    res_cnt_d    = res_cnt;
    res_ovf_d    = res_ovf;
    accept       = 1'b0;
    acc_base     = acc_q;
    cnt_base     = cnt_q;
    ovf_base     = ovf_q;
    sum          = '0;
    sum_ovf      = 1'b0;

    case (state_q)
      IDLE, ACC: begin
        accept   = prod_valid & prod_ready;
        // Clear takes effect before any same-cycle product or dump
        acc_base = acc_clr ? '0 : acc_q;
        cnt_base = acc_clr ? '0 : cnt_q;
        ovf_base = acc_clr ? 1'b0 : ovf_q;
        sum      = acc_base + prod_ext;
        sum_ovf  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_base[ACC_W-1]);
        acc_d    = acc_base;
        cnt_d    = cnt_base;
        ovf_d    = ovf_base;
        state_d  = acc_clr ? IDLE : state_q;
        if (accept) begin
          state_d = ACC;
          cnt_d   = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
          acc_d   = sum;
          if (sum_ovf) begin
            ovf_d = 1'b1;
            if (SAT_EN) acc_d = prod_ext[ACC_W-1] ? ACC_MIN : ACC_MAX;
          end
        end
        if (acc_dump) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_data_d  = acc_d;
          res_cnt_d   = cnt_d;
          res_ovf_d   = ovf_d;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    prod_ready_d = (state_d != HOLD);
  end

endmodule
